// File: rtl/keypad_event_encoder_pkg.sv
// Shared definitions for the front-panel input conditioning stage:
// key codes, key FSM state encoding and debounce defaults.
package keypad_event_encoder_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 20;
  localparam int unsigned NUM_KEYS            = 17;

  localparam logic [4:0] KEY_D0     = 5'd0;
  localparam logic [4:0] KEY_D1     = 5'd1;
  localparam logic [4:0] KEY_D2     = 5'd2;
  localparam logic [4:0] KEY_D3     = 5'd3;
  localparam logic [4:0] KEY_D4     = 5'd4;
  localparam logic [4:0] KEY_D5     = 5'd5;
  localparam logic [4:0] KEY_D6     = 5'd6;
  localparam logic [4:0] KEY_D7     = 5'd7;
  localparam logic [4:0] KEY_D8     = 5'd8;
  localparam logic [4:0] KEY_D9     = 5'd9;
  localparam logic [4:0] KEY_START  = 5'd10;
  localparam logic [4:0] KEY_CANCEL = 5'd11;
  localparam logic [4:0] KEY_CONF   = 5'd12;
  localparam logic [4:0] KEY_REC0   = 5'd13;
  localparam logic [4:0] KEY_REC1   = 5'd14;
  localparam logic [4:0] KEY_REC2   = 5'd15;
  localparam logic [4:0] KEY_REC3   = 5'd16;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } key_state_t;

  // True when exactly one key bit is set.
  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return (v != '0) && ((v & (v - 17'd1)) == '0);
  endfunction

  // Index of the lowest set bit; only meaningful for a one-hot vector.
  function automatic logic [4:0] key_index(input logic [NUM_KEYS-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int unsigned i = NUM_KEYS; i > 0; i--) begin
      if (v[i-1]) idx = 5'(i - 1);
    end
    return idx;
  endfunction

  // Single-bit mask for a key code.
  function automatic logic [NUM_KEYS-1:0] key_mask(input logic [4:0] code);
    return 17'(1) << code;
  endfunction

endpackage

// File: rtl/keypad_event_encoder_debounce_bit.sv
// Two-flop synchronizer plus stable-count debouncer for one level signal.
module debounce_bit
  import keypad_event_encoder_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W         = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // Bring the raw level into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
    end
  end

  // Count consecutive differing cycles; commit once STABLE_CYCLES have been
  // seen and the level still differs, which lines up with the key path latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (s2 != dout) begin
      if (cnt == CNT_W'(STABLE_CYCLES)) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/keypad_event_encoder.sv
// Front-panel conditioning: synchronizes and debounces keypad, config and
// recipe buttons into single-cycle key events, and debounces the door switch.
module keypad_event_encoder
  import keypad_event_encoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned CNT_W           = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] t,
  input  logic        conf,
  input  logic [3:0]  r,
  input  logic        porta,
  output logic        key_valid,
  output logic [4:0]  key_code,
  output logic        key_held,
  output logic        door_open
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] v;
  logic [NUM_KEYS-1:0] s1;
  logic [NUM_KEYS-1:0] sv;
  logic                vld1;
  logic                vld2;
  key_state_t          state;
  logic [CNT_W-1:0]    cnt;
  logic [4:0]          cand;
  logic                armed;

  assign v = {r, conf, t};

  // Two-flop synchronizer for the key vector, with a valid bit riding along
  // so the FSM can tell reset-cleared flops from a genuinely released panel.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= '0;
      sv   <= '0;
      vld1 <= 1'b0;
      vld2 <= 1'b0;
    end else begin
      s1   <= v;
      sv   <= s1;
      vld1 <= 1'b1;
      vld2 <= vld1;
    end
  end

  // Key FSM with registered outputs. A press only starts debounce once an
  // all-released vector has been seen since reset (armed), so a key held
  // through reset must be released and pressed again.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= '0;
      armed     <= 1'b0;
      key_valid <= 1'b0;
      key_code  <= KEY_D0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sv == '0) begin
            if (vld2) armed <= 1'b1;
          end else if (armed && is_onehot(sv)) begin
            cand  <= key_index(sv);
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (sv == key_mask(cand)) begin
            if (cnt == CNT_LAST) begin
              key_valid <= 1'b1;
              key_code  <= cand;
              key_held  <= 1'b1;
              state     <= HELD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        HELD: begin
          key_held <= 1'b1;
          if (sv == '0) begin
            cnt      <= '0;
            key_held <= 1'b0;
            state    <= RELEASE;
          end
        end
        RELEASE: begin
          if (sv == '0) begin
            if (cnt == CNT_LAST) state <= IDLE;
            else                 cnt   <= cnt + 1'b1;
          end else begin
            key_held <= 1'b1;
            state    <= HELD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  debounce_bit #(
    .STABLE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W        (CNT_W)
  ) u_door (
    .clk (clk),
    .rst (rst),
    .din (porta),
    .dout(door_open)
  );

endmodule

// File: tb/tb_keypad_event_encoder.sv
// Self-checking bench for keypad_event_encoder with an expected-event scoreboard.
module tb_keypad_event_encoder;

  localparam int DB  = 20;
  // Input driven at a negedge lands at edge k = next posedge; the event is
  // registered at edge k+2+DB and sampled on the following negedge.
  localparam int LAT = DB + 3;

  logic        clk;
  logic        rst;
  logic [11:0] t;
  logic        conf;
  logic [3:0]  r;
  logic        porta;
  logic        key_valid;
  logic [4:0]  key_code;
  logic        key_held;
  logic        door_open;

  typedef struct {
    int code;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_errors;
  logic mon_en;
  logic prev_valid;

  keypad_event_encoder #(
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .t        (t),
    .conf     (conf),
    .r        (r),
    .porta    (porta),
    .key_valid(key_valid),
    .key_code (key_code),
    .key_held (key_held),
    .door_open(door_open)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_key(input int code);
    exp_t e;
    e.code = code;
    e.cyc  = cyc + LAT;
    exp_q.push_back(e);
  endtask

  // Scoreboard monitor: every key_valid must match the next expected event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (key_valid) begin
        exp_t e;
        chk("no_double_pulse", 32'(prev_valid), 32'd0);
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(key_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("ev_code", 32'(key_code), 32'(e.code));
          chk("ev_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      prev_valid = key_valid;
    end
  end

  initial begin
    int c;
    cyc        = 0;
    n_checks   = 0;
    n_errors   = 0;
    mon_en     = 1'b0;
    prev_valid = 1'b0;
    rst        = 1'b1;
    t          = '0;
    conf       = 1'b0;
    r          = '0;
    porta      = 1'b0;
    wait_cyc(3);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_held", 32'(key_held), 32'd0);
    chk("rst_door", 32'(door_open), 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    wait_cyc(10);

    // Clean press of digit 5, then release.
    t[5] = 1'b1;
    expect_key(5);
    wait_cyc(100);
    t[5] = 1'b0;
    wait_cyc(2);
    chk("held_before_rel", 32'(key_held), 32'd1);
    wait_cyc(1);
    chk("held_after_rel", 32'(key_held), 32'd0);
    chk("code_kept", 32'(key_code), 32'd5);
    wait_cyc(100);

    // Bouncing press of digit 2: H L H L H then stays high.
    for (int i = 0; i < 5; i++) begin
      t[2] = (i % 2 == 0);
      if (i == 4) expect_key(2);
      wait_cyc(3);
    end
    wait_cyc(40);
    t[2] = 1'b0;
    wait_cyc(60);

    // Chord start+cancel is ignored; releasing cancel leaves start.
    t[10] = 1'b1;
    t[11] = 1'b1;
    wait_cyc(100);
    t[11] = 1'b0;
    expect_key(10);
    wait_cyc(100);
    t[10] = 1'b0;
    wait_cyc(60);

    // Recipe 2, config, long cancel hold.
    r[2] = 1'b1;
    expect_key(15);
    wait_cyc(100);
    r[2] = 1'b0;
    wait_cyc(60);
    conf = 1'b1;
    expect_key(12);
    wait_cyc(100);
    conf = 1'b0;
    wait_cyc(60);
    t[11] = 1'b1;
    expect_key(11);
    wait_cyc(500);
    t[11] = 1'b0;
    wait_cyc(60);

    // Door: short glitch, then a real open, then close.
    porta = 1'b1;
    wait_cyc(10);
    porta = 1'b0;
    chk("door_glitch", 32'(door_open), 32'd0);
    wait_cyc(10);
    porta = 1'b1;
    c = cyc;
    wait_cyc(LAT - 1);
    chk("door_rise_early", 32'(door_open), 32'd0);
    wait_cyc(1);
    chk("door_rise", 32'(door_open), 32'd1);
    chk("door_rise_cyc", 32'(cyc - c), 32'(LAT));
    wait_cyc(30 - LAT);
    porta = 1'b0;
    wait_cyc(LAT - 1);
    chk("door_fall_early", 32'(door_open), 32'd1);
    wait_cyc(1);
    chk("door_fall", 32'(door_open), 32'd0);
    wait_cyc(20);

    // Reset during debounce of digit 7 while the key stays held.
    t[7] = 1'b1;
    wait_cyc(10);
    rst = 1'b1;
    wait_cyc(1);
    chk("midrst_valid", 32'(key_valid), 32'd0);
    chk("midrst_code", 32'(key_code), 32'd0);
    chk("midrst_held", 32'(key_held), 32'd0);
    chk("midrst_door", 32'(door_open), 32'd0);
    rst = 1'b0;
    wait_cyc(60);
    t[7] = 1'b0;
    wait_cyc(30);
    t[7] = 1'b1;
    expect_key(7);
    wait_cyc(60);
    t[7] = 1'b0;
    wait_cyc(30);

    chk("pending_events", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_event_encoder.md
Name: keypad_event_encoder

Overview:
- Input conditioning stage directly upstream of the microwave controller top.
- Takes the raw front-panel contacts: keypad t[11:0] (digits 0-9, start, cancel), config button, recipe buttons r[3:0] and door switch.
- Produces synchronized, debounced, single-cycle key events with a 5-bit key code, plus a debounced door level.
- The controller FSM consumes one key_valid pulse per physical press and never sees bounce, hold repeats or multi-key chords.

Parameters:
- DEBOUNCE_CYCLES, 20: stable cycles required before a press or release is accepted. At the 1 kHz system tick this is 20 ms.
- CNT_W, 5: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock, one tick = 1 ms.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- t  in  12  raw keypad contacts, active-high. Bits 0-9 are digits, bit 10 is start, bit 11 is cancel.
- conf  in  1  raw config button, active-high.
- r  in  4  raw recipe buttons, active-high.
- porta  in  1  raw door switch, 1 = open.
- key_valid  out  1  one-cycle pulse, one per accepted press.
- key_code  out  5  code of the accepted key; held until the next accepted key.
- key_held  out  1  high while the accepted key remains pressed.
- door_open  out  1  debounced door level.

Behaviour:
- Raw vector v[16:0] = {r, conf, t}. v and porta each pass through a 2-flop synchronizer; the FSM sees only synchronized values.
- Code map:
  - t[i] -> i, for i = 0..11.
  - conf -> 12.
  - r[j] -> 13+j, for j = 0..3.
- Reset values: key_valid=0, key_code=0, key_held=0, door_open=0, FSM=IDLE, counters=0, synchronizer flops=0.
- FSM states and transitions:
  - IDLE
    - sv all-zero: stay.
    - sv exactly one-hot: latch index into cand, cnt=0, go DEBOUNCE.
    - sv with two or more bits set: ignore (chord reject) and stay IDLE. No event is generated until the vector becomes one-hot.
  - DEBOUNCE
    - sv == onehot(cand) and cnt == DEBOUNCE_CYCLES-1: register key_valid=1, key_code=cand, key_held=1, go HELD.
    - sv == onehot(cand) otherwise: cnt++.
    - Any other sv (bounce, release, second key): go IDLE with no event.
  - HELD
    - key_held=1.
    - sv all-zero: cnt=0, key_held=0, go RELEASE.
    - Otherwise stay. No repeat events, and extra keys pressed in HELD are ignored.
  - RELEASE
    - sv all-zero and cnt == DEBOUNCE_CYCLES-1: go IDLE.
    - sv all-zero otherwise: cnt++.
    - Any bit high: go back to HELD with key_held=1 and no new event (release bounce).
- Latency: raw key rises before edge k and is held stable -> key_valid is high in the cycle after edge k+2+DEBOUNCE_CYCLES, for exactly one cycle.
- Minimum press-to-press spacing: about 2*DEBOUNCE_CYCLES + 4 cycles.
- key_valid is never high for two consecutive cycles.
- Door path: an independent debouncer.
  - door_open takes the synchronized porta value after DEBOUNCE_CYCLES consecutive cycles that differ from the current door_open.
  - The counter clears on any cycle where sync porta equals door_open.
  - The door path is independent of the key FSM; door activity never blocks key events.
- Reset asserted mid-DEBOUNCE, HELD or RELEASE: the next cycle is in IDLE with all outputs 0 and no pending event. The key must then be released and pressed again to register.
- rst and an event completing in the same cycle: reset wins and key_valid stays 0.
- Counters saturate only via the FSM compare; they are never allowed to wrap.

Decomposition:
- Shared package holds:
  - Key code localparams: KEY_D0..KEY_D9 = 0..9, KEY_START = 10, KEY_CANCEL = 11, KEY_CONF = 12, KEY_REC0..KEY_REC3 = 13..16.
  - FSM state encoding: IDLE, DEBOUNCE, HELD, RELEASE.
  - The DEBOUNCE_CYCLES default.
- The controller top imports the same key code constants.
- One sub-module, debounce_bit: sync plus stable-count for a single level. It is used for the door path; the key path is an inline FSM.

Test Plan (DEBOUNCE_CYCLES=20):
- Press t[5] for 100 cycles, then release for 100 cycles -> exactly one key_valid, 22 cycles after the rise, with key_code=5. key_held stays high until about 2 cycles after release, and the FSM is back in IDLE 20 cycles later.
- t[2] toggling every 3 cycles for 15 cycles, then stable high for 40 cycles -> no event during the bounce. One event with key_code=2, 22 cycles after the last edge.
- Press t[10] and t[11] together for 100 cycles -> no event. Then release t[11] only -> one event with key_code=10.
- Press r[2] for 100 cycles -> key_code=15. Press conf for 100 cycles -> key_code=12. Hold t[11] for 500 cycles -> exactly one event (code 11).
- porta high for 10 cycles, low, then high for 30 cycles -> door_open rises only 22 cycles after the start of the second high. It falls 22 cycles after porta returns low.
- t[7] high, rst asserted 10 cycles after the rise and then deasserted while t[7] is still held -> no key_valid ever. All outputs are 0 one cycle after rst. A fresh press after release produces code 7.
